foreground_scanline: RTL

Scanline-buffered foreground (sprite) renderer: the parametrised successor to the combinational per-pixel foreground. Each line it scans Object Memory for objects intersecting the *next* scanline, accepts up to `SPRITES_PER_LINE` of them in priority order, and rasterises them into a ping-pong line buffer. The current line is shown from the other buffer. It sits between VRAM writes (PMF/OBM) and the pixel mixer, replacing the N-way parallel compare with a small sequential engine.

---
 rtl/foreground_scanline_if.sv | 29 ++
 rtl/foreground_scanline.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/foreground_scanline_if.sv
// Video timing, VRAM write bus and pixel output bundle of the scanline foreground renderer.
// The master side drives timing and VRAM writes; the slave side is the renderer.
interface foreground_scanline_if #(
    parameter int VRAM_ADDR_WIDTH = 12
);
    logic [7:0]                 xp;
    logic [7:0]                 yp;
    logic                       visible;
    logic                       writable;
    logic                       line_start;
    logic [7:0]                 data;
    logic [VRAM_ADDR_WIDTH-1:0] address;
    logic                       write_enable;
    logic [1:0]                 r;
    logic [1:0]                 g;
    logic [1:0]                 b;
    logic                       valid;
    logic                       overflow;

    modport master (
        output xp, yp, visible, writable, line_start, data, address, write_enable,
        input  r, g, b, valid, overflow
    );

    modport slave (
        input  xp, yp, visible, writable, line_start, data, address, write_enable,
        output r, g, b, valid, overflow
    );
endinterface

// File: rtl/foreground_scanline.sv
// Scanline-buffered sprite renderer: scans OBM for the next line, rasterises up to
// SPRITES_PER_LINE objects into a ping-pong line buffer. FOREGROUND_OVERFLOW_FLAG_EN adds the sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for line_start
// EVAL  | testing one OBM entry per cycle against the target line
// DRAW  | rasterising one pixel per cycle of each accepted slot
module foreground_scanline #(
    parameter int NUM_OBJECTS      = 64,
    parameter int SPRITES_PER_LINE = 8,
    parameter int VRAM_ADDR_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    foreground_scanline_if.slave bus
);
    localparam int SW = (SPRITES_PER_LINE > 1) ? $clog2(SPRITES_PER_LINE) : 1;
    localparam int CW = $clog2(SPRITES_PER_LINE + 1);
    localparam int EW = 21;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DRAW
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0] r_pmf      [512];
    logic [7:0] r_obm_x    [64];
    logic [7:0] r_obm_y    [64];
    logic [6:0] r_obm_attr [64];
    logic [2:0] r_obm_col  [64];

    logic [EW-1:0]    r_slot_mem [SPRITES_PER_LINE];
    logic [5:0]       r_lbuf     [2][256];
    logic [1:0][255:0] r_opq;

    logic             r_disp_sel;
    logic [7:0]       r_target;
    logic [5:0]       r_idx;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_slot;
    logic [2:0]       r_pix;
    logic [1:0]       r_r;
    logic [1:0]       r_g;
    logic [1:0]       r_b;
    logic             r_valid;

    logic             w_we;
    logic             w_pmf_sel;
    logic             w_obm_sel;

    assign w_we      = bus.write_enable & bus.writable;
    assign w_pmf_sel = (bus.address[VRAM_ADDR_WIDTH-1:9] == '0);
    assign w_obm_sel = (bus.address[VRAM_ADDR_WIDTH-1:8] == (VRAM_ADDR_WIDTH-8)'(8'h08));

    // Pattern and object memories are not reset; reads are combinational so a
    // same-cycle write is seen by the renderer only from the next cycle on.
    always_ff @(posedge clk) begin
        if (w_we && w_pmf_sel) begin
            r_pmf[bus.address[8:0]] <= bus.data;
        end
        if (w_we && w_obm_sel) begin
            case (bus.address[1:0])
                2'd0:    r_obm_x[bus.address[7:2]]    <= bus.data;
                2'd1:    r_obm_y[bus.address[7:2]]    <= bus.data;
                2'd2:    r_obm_attr[bus.address[7:2]] <= bus.data[6:0];
                default: r_obm_col[bus.address[7:2]]  <= bus.data[2:0];
            endcase
        end
    end

    logic [8:0]    w_dy;
    logic          w_hit;
    logic          w_full;
    logic          w_accept;
    logic          w_eval_last;
    logic          w_empty;
    logic [EW-1:0] w_new_ent;

    // Nine-bit difference: objects near the bottom never wrap onto line 0.
    assign w_dy        = {1'b0, r_target} - {1'b0, r_obm_y[r_idx]};
    assign w_hit       = (r_state == S_EVAL) && (w_dy[8:3] == 6'd0);
    assign w_full      = (r_cnt == CW'(SPRITES_PER_LINE));
    assign w_accept    = w_hit && !w_full;
    assign w_eval_last = (r_idx == 6'(NUM_OBJECTS - 1));
    assign w_empty     = (r_cnt == '0) && !w_accept;
    assign w_new_ent   = {r_obm_attr[r_idx][4:0], r_obm_attr[r_idx][6], r_obm_attr[r_idx][5],
                          r_obm_col[r_idx], r_obm_x[r_idx], w_dy[2:0]};

    logic [EW-1:0] w_ent;
    logic [4:0]    w_pmfa;
    logic          w_hflip;
    logic          w_vflip;
    logic [2:0]    w_col;
    logic [7:0]    w_x;
    logic [2:0]    w_row;
    logic [7:0]    w_line_idx;
    logic [15:0]   w_line;
    logic [2:0]    w_src;
    logic [1:0]    w_px;
    logic [8:0]    w_dest;
    logic          w_rsel;
    logic          w_write;
    logic          w_pix_last;
    logic          w_slot_last;

    assign w_ent = r_slot_mem[r_slot];
    assign {w_pmfa, w_hflip, w_vflip, w_col, w_x, w_row} = w_ent;

    // Pixel 0 sits in the top two bits of the 16-bit pattern line.
    assign w_line_idx  = {w_pmfa, (w_vflip ? ~w_row : w_row)};
    assign w_line      = {r_pmf[{w_line_idx, 1'b0}], r_pmf[{w_line_idx, 1'b1}]};
    assign w_src       = w_hflip ? ~r_pix : r_pix;
    assign w_px        = w_line[{~w_src, 1'b0} +: 2];
    assign w_dest      = {1'b0, w_x} + {6'd0, r_pix};
    assign w_rsel      = ~r_disp_sel;
    assign w_pix_last  = (r_pix == 3'd7);
    assign w_slot_last = ((CW'(r_slot) + CW'(1)) == r_cnt);
    assign w_write     = (r_state == S_DRAW) && !bus.line_start && (w_px != 2'd0) &&
                         !w_dest[8] && !r_opq[w_rsel][w_dest[7:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EVAL: begin
                if (w_eval_last) begin
                    w_next = w_empty ? S_IDLE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_pix_last && w_slot_last) begin
                    w_next = S_IDLE;
                end
            end
            default: ;
        endcase
        if (bus.line_start) begin
            w_next = S_EVAL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp_sel <= 1'b0;
            r_opq      <= '0;
            r_target   <= 8'd0;
            r_idx      <= 6'd0;
            r_cnt      <= '0;
            r_slot     <= '0;
            r_pix      <= 3'd0;
        end else if (bus.line_start) begin
            // The outgoing display buffer becomes the render buffer.
            r_disp_sel        <= ~r_disp_sel;
            r_opq[r_disp_sel] <= '0;
            r_target          <= bus.yp + 8'd1;
            r_idx             <= 6'd0;
            r_cnt             <= '0;
            r_slot            <= '0;
            r_pix             <= 3'd0;
        end else begin
            if (r_state == S_EVAL) begin
                r_idx <= r_idx + 6'd1;
                if (w_accept) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (r_state == S_DRAW) begin
                r_pix <= r_pix + 3'd1;
                if (w_pix_last) begin
                    r_slot <= r_slot + SW'(1);
                end
            end
            if (w_write) begin
                r_opq[w_rsel][w_dest[7:0]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !bus.line_start) begin
            r_slot_mem[r_cnt[SW-1:0]] <= w_new_ent;
        end
        if (w_write) begin
            r_lbuf[w_rsel][w_dest[7:0]] <= {(w_col[2] ? w_px : 2'd0),
                                            (w_col[1] ? w_px : 2'd0),
                                            (w_col[0] ? w_px : 2'd0)};
        end
    end

    // Colour RAM is never cleared, so the opaque bit also gates the colour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r     <= 2'd0;
            r_g     <= 2'd0;
            r_b     <= 2'd0;
            r_valid <= 1'b0;
        end else if (bus.visible && r_opq[r_disp_sel][bus.xp]) begin
            {r_r, r_g, r_b} <= r_lbuf[r_disp_sel][bus.xp];
            r_valid         <= 1'b1;
        end else begin
            r_r     <= 2'd0;
            r_g     <= 2'd0;
            r_b     <= 2'd0;
            r_valid <= 1'b0;
        end
    end

    assign bus.r     = r_r;
    assign bus.g     = r_g;
    assign bus.b     = r_b;
    assign bus.valid = r_valid;

`ifdef FOREGROUND_OVERFLOW_FLAG_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = w_hit && w_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (bus.line_start) begin
            r_overflow <= ((bus.yp != 8'd0) && r_overflow) || (r_state != S_IDLE);
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`else
    assign bus.overflow = 1'b0;
`endif

endmodule
